// File: rtl/uart_pkg.sv
// Shared types for the UART result path.
// Byte type, sequencer states and checksum seed.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    GAP,
    FINISH
  } tx_seq_state_t;

  localparam byte_t CHK_INIT = 8'h00;

endpackage

// File: rtl/tx_cycle_timer.sv
// Clear/enable cycle counter with terminal-count compare.
// Saturates at all-ones instead of wrapping.
module tx_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while enabled until full.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == tc_i);

endmodule

// File: rtl/tx_result_sequencer.sv
// Sends the result word LSB byte first over the uart_tx handshake.
// Build option TX_CHECKSUM_EN appends an XOR checksum byte.
module tx_result_sequencer
  import uart_pkg::*;
#(
  parameter int NBYTES      = 2,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic [8*NBYTES-1:0] result,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                trig_dropped
);

`ifdef TX_CHECKSUM_EN
  localparam int NTOT = NBYTES + 1;
`else
  localparam int NTOT = NBYTES;
`endif

  localparam int IW   = $clog2(NTOT + 1);
  localparam int TMAX = (GAP_CYCLES > ACK_TIMEOUT) ?
                        GAP_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [IW-1:0] LAST   = IW'(NTOT - 1);
  localparam logic [TW-1:0] ACK_TC = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_TC =
    TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_seq_state_t       state_q, state_d;
  logic [8*NBYTES-1:0] shreg_q, shreg_d;
  logic [IW-1:0]       idx_q, idx_d;
  byte_t               data_q, data_d;

`ifdef TX_CHECKSUM_EN
  byte_t               chk_q, chk_d;
`endif

  logic                tmr_clr;
  logic                tmr_en;
  logic [TW-1:0]       tmr_tc;
  logic                tmr_hit;

  tx_cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_i  (tmr_tc),
    .tc_o  (tmr_hit)
  );

  // Next-state, datapath and timer control for the byte sequencer.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    data_d  = data_q;
`ifdef TX_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    tmr_tc  = ACK_TC;
    error   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          shreg_d = result;
          idx_d   = '0;
`ifdef TX_CHECKSUM_EN
          chk_d   = CHK_INIT;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        tmr_tc  = ACK_TC;
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmr_hit) begin
          error   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          shreg_d = shreg_q >> 8;
          idx_d   = idx_q + 1'b1;
`ifdef TX_CHECKSUM_EN
          chk_d   = chk_q ^ shreg_q[7:0];
          if (idx_q == IW'(NBYTES - 1))
            shreg_d[7:0] = chk_d;
`endif
          if (idx_q == LAST)
            state_d = FINISH;
          else if (GAP_CYCLES == 0)
            state_d = SEND;
          else
            state_d = GAP;
        end
      end
      GAP: begin
        tmr_clr = 1'b0;
        tmr_en  = 1'b1;
        tmr_tc  = GAP_TC;
        if (tmr_hit)
          state_d = SEND;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == SEND)
      data_d = shreg_d[7:0];
  end

  // State and datapath registers; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef TX_CHECKSUM_EN
      chk_q   <= CHK_INIT;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef TX_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign tx_start     = (state_q == SEND);
  assign tx_data      = data_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign trig_dropped = trigger && busy;

endmodule

// File: tb/tb_tx_result_sequencer.sv
// Directed scoreboard bench for tx_result_sequencer.
// Two instances: default gap, and back-to-back bytes.
module tb_tx_result_sequencer;

`ifdef TX_CHECKSUM_EN
  localparam int NTOT = 3;
`else
  localparam int NTOT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger, trigger0;
  logic [15:0] result, result0;
  logic        tx_busy, tx_busy0;
  logic        tx_start, tx_start0;
  logic [7:0]  tx_data, tx_data0;
  logic        busy, busy0;
  logic        done, done0;
  logic        error, error0;
  logic        trig_dropped, trig_dropped0;

  int ncmp = 0;
  int nmis = 0;
  int cyc  = 0;

  int mcnt  = 0;
  int mcnt0 = 0;
  bit ack_en = 1'b1;

  logic [7:0] exp_q[$];
  int st_t[$];
  int fall_t[$];
  int s0_t[$];
  int f0_t[$];
  logic [7:0] s0_d[$];

  int done_cnt = 0, done_t = 0;
  int err_cnt  = 0, err_t  = 0;
  int drop_cnt = 0;
  int done0_cnt = 0;
  logic prev_busy = 1'b0, prev_busy0 = 1'b0;

  tx_result_sequencer #(
    .NBYTES      (2),
    .GAP_CYCLES  (16),
    .ACK_TIMEOUT (8)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .trigger      (trigger),
    .result       (result),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .trig_dropped (trig_dropped)
  );

  tx_result_sequencer #(
    .NBYTES      (2),
    .GAP_CYCLES  (0),
    .ACK_TIMEOUT (8)
  ) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .trigger      (trigger0),
    .result       (result0),
    .tx_busy      (tx_busy0),
    .tx_start     (tx_start0),
    .tx_data      (tx_data0),
    .busy         (busy0),
    .done         (done0),
    .error        (error0),
    .trig_dropped (trig_dropped0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx models: busy 1 cycle after start, held 10 cycles.
  always @(posedge clk) begin
    if (tx_start && ack_en) mcnt <= 10;
    else if (mcnt != 0)     mcnt <= mcnt - 1;
    if (tx_start0)          mcnt0 <= 10;
    else if (mcnt0 != 0)    mcnt0 <= mcnt0 - 1;
  end

  assign tx_busy  = (mcnt != 0);
  assign tx_busy0 = (mcnt0 != 0);

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop scoreboard on each tx_start, log event times.
  always @(negedge clk) begin
    logic [7:0] ex;
    if (tx_start) begin
      st_t.push_back(cyc);
      chk("start_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(ex));
      end
    end
    if (prev_busy && !tx_busy) fall_t.push_back(cyc);
    prev_busy = tx_busy;
    if (done) begin done_cnt++; done_t = cyc; end
    if (error) begin err_cnt++; err_t = cyc; end
    if (trig_dropped) drop_cnt++;
    if (tx_start0) begin
      s0_t.push_back(cyc);
      s0_d.push_back(tx_data0);
    end
    if (prev_busy0 && !tx_busy0) f0_t.push_back(cyc);
    prev_busy0 = tx_busy0;
    if (done0) done0_cnt++;
  end

  task automatic wait_cnt(input string tag, input int target,
                          input int budget, input int sel);
    int n;
    int v;
    n = 0;
    v = (sel == 0) ? done_cnt : (sel == 1) ? err_cnt : done0_cnt;
    while (v < target && n < budget) begin
      tick();
      n++;
      v = (sel == 0) ? done_cnt : (sel == 1) ? err_cnt : done0_cnt;
    end
    chk(tag, 32'(v >= target), 32'd1);
  endtask

  task automatic clr_logs();
    exp_q.delete();
    st_t.delete();
    fall_t.delete();
  endtask

  initial begin
    int t0;
    int d0;
    int n;
    reset    = 1'b1;
    trigger  = 1'b0;
    trigger0 = 1'b0;
    result   = '0;
    result0  = '0;
    repeat (3) tick();

    chk("rst_ctrl", 32'({tx_start, busy, done, error, trig_dropped}), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    tick();

    // Normal transfer with a dropped mid-transfer trigger.
    clr_logs();
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    if (NTOT == 3) exp_q.push_back(8'h51);
    t0 = cyc;
    trigger = 1'b1;
    result  = 16'hBEEF;
    tick();
    trigger = 1'b0;
    result  = 16'h0000;
    repeat (5) tick();
    trigger = 1'b1;
    result  = 16'h1234;
    tick();
    trigger = 1'b0;
    result  = 16'h0000;
    wait_cnt("done_timeout", 1, 400, 0);
    chk("start_latency", 32'(st_t.size() > 0 ? st_t[0] - t0 : -1), 32'd1);
    chk("start_count", 32'(st_t.size()), 32'(NTOT));
    if (st_t.size() >= 2 && fall_t.size() >= 1)
      chk("gap16", 32'(st_t[1] - fall_t[0]), 32'd17);
    else
      chk("gap16_events", 32'(st_t.size()), 32'd2);
    chk("done_after_fall",
        32'(fall_t.size() >= NTOT ? done_t - fall_t[NTOT-1] : -1), 32'd1);
    chk("dropped", 32'(drop_cnt), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    chk("idle_after_done", 32'(busy), 32'd0);
    repeat (3) tick();

    // Ack timeout: model never answers.
    clr_logs();
    ack_en = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(8'hEF);
    trigger = 1'b1;
    result  = 16'hBEEF;
    tick();
    trigger = 1'b0;
    wait_cnt("error_timeout", 1, 50, 1);
    chk("error_latency", 32'(st_t.size() > 0 ? err_t - st_t[0] : -1), 32'd8);
    repeat (5) tick();
    chk("busy_after_err", 32'(busy), 32'd0);
    chk("starts_after_err", 32'(st_t.size()), 32'd1);
    chk("no_done_on_err", 32'(done_cnt), 32'(d0));
    chk("err_count", 32'(err_cnt), 32'd1);
    ack_en = 1'b1;

    // Reset in WAIT_DONE of byte 0, then restart.
    clr_logs();
    exp_q.push_back(8'hEF);
    trigger = 1'b1;
    result  = 16'hBEEF;
    tick();
    trigger = 1'b0;
    repeat (5) tick();
    chk("in_wait_done", 32'({busy, tx_busy}), 32'b11);
    reset = 1'b1;
    tick();
    chk("rst_mid_ctrl", 32'({tx_start, busy, done, error, trig_dropped}), 32'd0);
    chk("rst_mid_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    n = 0;
    while (tx_busy && n < 30) begin
      tick();
      n++;
    end
    chk("model_idle", 32'(tx_busy), 32'd0);
    repeat (3) tick();
    chk("no_start_after_rst", 32'(st_t.size()), 32'd1);
    clr_logs();
    d0 = done_cnt;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    if (NTOT == 3) exp_q.push_back(8'hFF);
    trigger = 1'b1;
    result  = 16'hA55A;
    tick();
    trigger = 1'b0;
    wait_cnt("restart_timeout", d0 + 1, 400, 0);
    chk("restart_count", 32'(st_t.size()), 32'(NTOT));
    chk("restart_queue", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    // Zero-gap instance: next byte right after busy falls.
    s0_t.delete();
    s0_d.delete();
    f0_t.delete();
    trigger0 = 1'b1;
    result0  = 16'hC3A1;
    tick();
    trigger0 = 1'b0;
    result0  = 16'h0000;
    wait_cnt("gap0_timeout", 1, 400, 2);
    chk("gap0_count", 32'(s0_t.size()), 32'(NTOT));
    chk("gap0_b0", 32'(s0_d.size() > 0 ? s0_d[0] : 8'h00), 32'h0A1);
    chk("gap0_b1", 32'(s0_d.size() > 1 ? s0_d[1] : 8'h00), 32'h0C3);
    chk("gap0_gap",
        32'(s0_t.size() > 1 && f0_t.size() > 0 ? s0_t[1] - f0_t[0] : -1),
        32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
